// File: rtl/mem_subsystem_if.sv
// Request/response bundle for one port of mem_subsystem.
// The err signal exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_subsystem_if #(
    parameter int XLEN = 32
);
    logic                  req;
    logic [XLEN-1:0]       addr;
    logic [XLEN/8-1:0]     be;
    logic [XLEN-1:0]       wdata;
    logic                  busy;
    logic                  valid;
    logic [XLEN-1:0]       rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic                  err;

    modport master (output req, addr, be, wdata, input busy, valid, rdata, err);
    modport slave  (input req, addr, be, wdata, output busy, valid, rdata, err);
`else
    modport master (output req, addr, be, wdata, input busy, valid, rdata);
    modport slave  (input req, addr, be, wdata, output busy, valid, rdata);
`endif
endinterface

// File: rtl/mem_subsystem.sv
// Dual-port instruction/data memory with pipelined reads, byte-enable writes and PC registers.
// Optional fault detection (misaligned/out-of-range) enabled by MEM_ALIGN_CHECK_EN.
module mem_subsystem #(
    parameter int              XLEN        = 32,
    parameter int              INSTR_WORDS = 256,
    parameter int              DATA_WORDS  = 256,
    parameter int              RD_LAT      = 1,
    parameter logic [XLEN-1:0] PC_RESET    = '0
) (
    input  logic            clk,
    input  logic            rst,
    mem_subsystem_if.slave  p1,
    mem_subsystem_if.slave  p2,
    input  logic            pc_we,
    input  logic            pc_inc,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out,
    input  logic            old_pc_we,
    output logic [XLEN-1:0] old_pc_out
);
    localparam int NB    = XLEN / 8;
    localparam int WORDS = INSTR_WORDS + DATA_WORDS;
    localparam int IW    = XLEN - 2;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [XLEN-1:0] r_mem [WORDS];

    logic [1:0]           w_req, w_busy, w_acc, w_inr, w_ok, w_rd, w_wr, w_isw;
    logic [1:0][XLEN-1:0] w_addr, w_wdata;
    logic [1:0][NB-1:0]   w_be;
    logic [1:0][IW-1:0]   w_idx;
    logic [1:0][AW-1:0]   w_widx;
    logic                 w_coll;

    assign w_req   = {p2.req, p1.req};
    assign w_addr  = {p2.addr, p1.addr};
    assign w_be    = {p2.be, p1.be};
    assign w_wdata = {p2.wdata, p1.wdata};

    always_comb begin
        w_coll = 1'b0;
        for (int p = 0; p < 2; p++) begin
            w_idx[p]  = w_addr[p][XLEN-1:2];
            w_widx[p] = w_idx[p][AW-1:0];
            w_isw[p]  = |w_be[p];
            w_inr[p]  = (w_idx[p] < IW'(WORDS));
`ifdef MEM_ALIGN_CHECK_EN
            w_ok[p]   = w_inr[p] && (w_addr[p][1:0] == 2'b00);
`else
            w_ok[p]   = w_inr[p];
`endif
        end
        // Same-word double write: p1 wins, p2 is stalled and must hold.
        w_coll    = w_req[0] && w_req[1] && w_isw[0] && w_isw[1] && (w_idx[0] == w_idx[1]);
        w_busy    = {w_coll, 1'b0};
        w_acc     = w_req & ~w_busy;
        w_wr      = w_acc & w_isw & w_ok;
`ifdef MEM_ALIGN_CHECK_EN
        w_rd      = w_acc & ~w_isw & w_ok;
`else
        w_rd      = w_acc & ~w_isw;
`endif
    end

`ifndef MEM_ALIGN_CHECK_EN
    logic w_unused_lsb;
    assign w_unused_lsb = ^{p1.addr[1:0], p2.addr[1:0]};
`endif

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < NB; b++)
                if (w_wr[p] && w_be[p][b])
                    r_mem[w_widx[p]][b*8 +: 8] <= w_wdata[p][b*8 +: 8];
    end

    // Read pipeline; data stages only load behind a valid so rdata holds between pulses.
    logic [1:0][RD_LAT-1:0]           r_vld;
    logic [1:0][RD_LAT-1:0][XLEN-1:0] r_dat;
`ifdef MEM_ALIGN_CHECK_EN
    logic [1:0][RD_LAT-1:0]           r_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_dat <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_err <= '0;
`endif
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p][0] <= w_rd[p];
                if (w_rd[p])
                    r_dat[p][0] <= w_inr[p] ? r_mem[w_widx[p]] : '0;
`ifdef MEM_ALIGN_CHECK_EN
                r_err[p][0] <= w_acc[p] && !w_ok[p];
`endif
                for (int s = 1; s < RD_LAT; s++) begin
                    r_vld[p][s] <= r_vld[p][s-1];
                    if (r_vld[p][s-1])
                        r_dat[p][s] <= r_dat[p][s-1];
`ifdef MEM_ALIGN_CHECK_EN
                    r_err[p][s] <= r_err[p][s-1];
`endif
                end
            end
        end
    end

    assign p1.busy  = w_busy[0];
    assign p2.busy  = w_busy[1];
    assign p1.valid = r_vld[0][RD_LAT-1];
    assign p2.valid = r_vld[1][RD_LAT-1];
    assign p1.rdata = r_dat[0][RD_LAT-1];
    assign p2.rdata = r_dat[1][RD_LAT-1];
`ifdef MEM_ALIGN_CHECK_EN
    assign p1.err   = r_err[0][RD_LAT-1];
    assign p2.err   = r_err[1][RD_LAT-1];
`endif

    logic [XLEN-1:0] r_pc, r_old_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= PC_RESET;
            r_old_pc <= '0;
        end else begin
            if (pc_we)
                r_pc <= pc_in;
            else if (pc_inc)
                r_pc <= r_pc + XLEN'(4);
            if (old_pc_we)
                r_old_pc <= r_pc;
        end
    end

    assign pc_out     = r_pc;
    assign old_pc_out = r_old_pc;
endmodule

// File: tb/tb_mem_subsystem.sv
// Directed bench for mem_subsystem; read results are scoreboarded against their expected slot.
module tb_mem_subsystem;
    localparam int          RD_LAT   = 3;
    localparam logic [31:0] PC_RST   = 32'h0000_0040;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pc_we = 1'b0, pc_inc = 1'b0, old_pc_we = 1'b0;
    logic [31:0] pc_in = '0, pc_out, old_pc_out;

    mem_subsystem_if #(.XLEN(32)) bus1 ();
    mem_subsystem_if #(.XLEN(32)) bus2 ();

    mem_subsystem #(
        .XLEN(32), .INSTR_WORDS(256), .DATA_WORDS(768), .RD_LAT(RD_LAT), .PC_RESET(PC_RST)
    ) dut (
        .clk(clk), .rst(rst), .p1(bus1), .p2(bus2),
        .pc_we(pc_we), .pc_inc(pc_inc), .pc_in(pc_in), .pc_out(pc_out),
        .old_pc_we(old_pc_we), .old_pc_out(old_pc_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; int due; } exp_t;
    exp_t q1[$], q2[$];
    int   edges = 0;
    int   vecs = 0, errs = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: each valid must match the head entry both in data and in cycle slot.
    always @(negedge clk) if (rst) begin
        if (bus1.valid) begin
            if (q1.size() == 0) chk("p1 spurious valid", bus1.valid, 1'b0);
            else begin
                chk("p1 valid slot", edges, q1[0].due);
                chk("p1 rdata", bus1.rdata, q1[0].d);
                void'(q1.pop_front());
            end
        end else if (q1.size() != 0 && q1[0].due <= edges) begin
            chk("p1 missing valid", bus1.valid, 1'b1);
            void'(q1.pop_front());
        end
        if (bus2.valid) begin
            if (q2.size() == 0) chk("p2 spurious valid", bus2.valid, 1'b0);
            else begin
                chk("p2 valid slot", edges, q2[0].due);
                chk("p2 rdata", bus2.rdata, q2[0].d);
                void'(q2.pop_front());
            end
        end else if (q2.size() != 0 && q2[0].due <= edges) begin
            chk("p2 missing valid", bus2.valid, 1'b1);
            void'(q2.pop_front());
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus1.req = 0; bus1.be = '0; bus1.addr = '0; bus1.wdata = '0;
        bus2.req = 0; bus2.be = '0; bus2.addr = '0; bus2.wdata = '0;
        pc_we = 0; pc_inc = 0; old_pc_we = 0;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        if (p == 1) begin bus1.req = 1; bus1.addr = a; bus1.be = be; bus1.wdata = d; end
        else        begin bus2.req = 1; bus2.addr = a; bus2.be = be; bus2.wdata = d; end
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] exp);
        exp_t e;
        e.d = exp; e.due = edges + RD_LAT;
        if (p == 1) begin bus1.req = 1; bus1.addr = a; bus1.be = '0; q1.push_back(e); end
        else        begin bus2.req = 1; bus2.addr = a; bus2.be = '0; q2.push_back(e); end
    endtask

    task automatic drain();
        idle();
        repeat (RD_LAT + 1) step();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc_out", pc_out, PC_RST);
        chk("reset old_pc_out", old_pc_out, 32'h0);
        chk("reset p1 valid", bus1.valid, 1'b0);
        chk("reset p2 valid", bus2.valid, 1'b0);
        chk("reset p1 rdata", bus1.rdata, 32'h0);
        chk("reset p2 rdata", bus2.rdata, 32'h0);
        rst = 1;

        // PC increment, then load with simultaneous old_pc capture
        pc_inc = 1;
        repeat (3) step();
        pc_inc = 0;
        chk("pc after 3 inc", pc_out, PC_RST + 32'd12);
        pc_we = 1; pc_inc = 1; pc_in = 32'h100; old_pc_we = 1;
        step(); idle();
        chk("pc load priority", pc_out, 32'h100);
        chk("old_pc capture", old_pc_out, PC_RST + 32'd12);
        pc_we = 1; pc_in = 32'hFFFF_FFFC; step(); idle();
        pc_inc = 1; step(); idle();
        chk("pc wrap", pc_out, 32'h0);
        chk("old_pc hold", old_pc_out, PC_RST + 32'd12);

        // Byte-enable writes
        wr(1, 32'h400, 4'b1111, 32'hAABB_CCDD); step();
        wr(1, 32'h400, 4'b0010, 32'h0000_1100); step(); idle();
        rd(1, 32'h400, 32'hAABB_11DD); step(); drain();

        // Four back-to-back p2 reads of preloaded words
        for (int i = 0; i < 4; i++) begin
            wr(1, 32'h500 + 32'(4*i), 4'hF, 32'hC0DE_0000 + 32'(i*17)); step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd(2, 32'h500 + 32'(4*i), 32'hC0DE_0000 + 32'(i*17)); step();
        end
        drain();

        // Same-word write collision: p1 wins, p2 stalls and retries
        wr(1, 32'h800, 4'hF, 32'h1111_1111);
        wr(2, 32'h800, 4'hF, 32'h2222_2222);
        @(negedge clk);
        chk("collision p2_busy", bus2.busy, 1'b1);
        chk("collision p1_busy", bus1.busy, 1'b0);
        step();
        bus1.req = 0; bus1.be = '0;
        @(negedge clk);
        chk("retry p2_busy", bus2.busy, 1'b0);
        step(); idle();
        rd(1, 32'h800, 32'h2222_2222); step(); drain();

        // Different words on the same cycle do not collide
        wr(1, 32'h804, 4'hF, 32'h5555_0001);
        wr(2, 32'h808, 4'hF, 32'h5555_0002);
        @(negedge clk);
        chk("no collision p2_busy", bus2.busy, 1'b0);
        step(); idle();
        rd(1, 32'h808, 32'h5555_0002);
        rd(2, 32'h804, 32'h5555_0001);
        @(negedge clk);
        chk("dual read p2_busy", bus2.busy, 1'b0);
        step(); drain();

        // Read-first on same word same edge
        rd(1, 32'h800, 32'h2222_2222);
        wr(2, 32'h800, 4'hF, 32'h3333_3333); step(); idle();
        rd(1, 32'h800, 32'h3333_3333); step(); drain();

        // Out-of-range write must not alias onto word 0
        wr(1, 32'h0, 4'hF, 32'h0BAD_F00D); step(); idle();
        wr(1, 32'h1000, 4'hF, 32'hDEAD_BEEF); step(); idle();
        rd(2, 32'h0, 32'h0BAD_F00D); step(); drain();
`ifndef MEM_ALIGN_CHECK_EN
        rd(1, 32'h1000, 32'h0); step(); drain();
`endif

        // Reset while a read is in flight: dropped, no valid
        rd(1, 32'h400, 32'hAABB_11DD); step(); idle();
        #2 rst = 0;
        q1.delete();
        #2;
        chk("mid reset pc_out", pc_out, PC_RST);
        chk("mid reset p1 rdata", bus1.rdata, 32'h0);
        rst = 1;
        for (int i = 0; i < RD_LAT + 1; i++) begin
            @(negedge clk);
            chk("dropped read valid", bus1.valid, 1'b0);
        end
        step();

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned read faults instead of returning data
        rd(1, 32'h402, 32'h0);
        void'(q1.pop_back());
        step(); idle();
        repeat (RD_LAT - 1) step();
        @(negedge clk);
        chk("misaligned p1_err", bus1.err, 1'b1);
        chk("misaligned p1_valid", bus1.valid, 1'b0);
        step();
        chk("err one-cycle pulse", bus1.err, 1'b0);
`endif

        drain();
        chk("p1 queue empty", 32'(q1.size()), 32'h0);
        chk("p2 queue empty", 32'(q2.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
